// File: rtl/store_commit_buffer.sv
// store_commit_buffer: accepts retired stores, formats byte enables and
// lane-replicated data, queues them in order and drains them to the data
// memory write port. Also provides store-to-load forwarding for younger loads.
module store_commit_buffer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             store_wb,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic             st_is_half,
    input  logic [TAG_W-1:0] st_rob_tag,
    output logic             buf_full,
    output logic             buf_empty,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ready,
    output logic             ack_valid,
    output logic [TAG_W-1:0] ack_tag,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [3:0]       ld_be,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data,
    output logic             ld_stall,
    output logic             misalign_err,
    output logic             overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [29:0]            addr_q  [DEPTH];
    logic [29:0]            addr_d  [DEPTH];
    logic [31:0]            wdata_q [DEPTH];
    logic [31:0]            wdata_d [DEPTH];
    logic [3:0]             be_q    [DEPTH];
    logic [3:0]             be_d    [DEPTH];
    logic [TAG_W-1:0]       tag_q   [DEPTH];
    logic [TAG_W-1:0]       tag_d   [DEPTH];

    // Pointers and occupancy
    logic [PW-1:0]          w_ptr_q, w_ptr_d;
    logic [PW-1:0]          r_ptr_q, r_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    // Registered status pulses
    logic                   ack_valid_q, ack_valid_d;
    logic [TAG_W-1:0]       ack_tag_q, ack_tag_d;
    logic                   misalign_err_q, misalign_err_d;
    logic                   overflow_err_q, overflow_err_d;

    // Formatting and handshake terms
    logic                   aligned;
    logic [3:0]             fmt_be;
    logic [31:0]            fmt_wdata;
    logic                   full;
    logic                   head_valid;
    logic                   pop;
    logic                   enq;

    // Load address byte offset is implied by ld_be
    logic                   unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];

    // Store alignment check and write data / byte enable formatting
    always_comb begin
        aligned   = 1'b0;
        fmt_be    = 4'b1111;
        fmt_wdata = st_data;
        if (st_is_half) begin
            aligned   = ~st_addr[0];
            fmt_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            fmt_wdata = {st_data[15:0], st_data[15:0]};
        end else begin
            aligned   = (st_addr[1:0] == 2'b00);
        end
    end

    assign full       = (count_q == CW'(DEPTH));
    assign head_valid = valid_q[r_ptr_q];
    assign pop        = head_valid & mem_ready;
    assign enq        = store_wb & aligned & (~full | pop);

    // Drain port driven straight from the head entry; zeroed when empty
    always_comb begin
        mem_we    = head_valid;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (head_valid) begin
            mem_addr  = {addr_q[r_ptr_q], 2'b00};
            mem_wdata = wdata_q[r_ptr_q];
            mem_be    = be_q[r_ptr_q];
        end
    end

    assign buf_full     = full;
    assign buf_empty    = (count_q == '0);
    assign ack_valid    = ack_valid_q;
    assign ack_tag      = ack_tag_q;
    assign misalign_err = misalign_err_q;
    assign overflow_err = overflow_err_q;

    // Next-state: pop clears the head, enqueue writes at w_ptr (enqueue wins
    // when both hit the same slot in the full-plus-pop case)
    always_comb begin
        valid_d        = valid_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        tag_d          = tag_q;
        w_ptr_d        = w_ptr_q;
        r_ptr_d        = r_ptr_q;
        count_d        = count_q;
        ack_valid_d    = pop;
        ack_tag_d      = ack_tag_q;
        misalign_err_d = store_wb & ~aligned;
        overflow_err_d = store_wb & aligned & full & ~pop;

        if (pop) begin
            valid_d[r_ptr_q] = 1'b0;
            ack_tag_d        = tag_q[r_ptr_q];
            r_ptr_d          = r_ptr_q + PW'(1);
        end

        if (enq) begin
            valid_d[w_ptr_q] = 1'b1;
            addr_d[w_ptr_q]  = st_addr[31:2];
            wdata_d[w_ptr_q] = fmt_wdata;
            be_d[w_ptr_q]    = fmt_be;
            tag_d[w_ptr_q]   = st_rob_tag;
            w_ptr_d          = w_ptr_q + PW'(1);
        end

        if (enq && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers with synchronous reset; payload storage is not reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= '0;
            w_ptr_q        <= '0;
            r_ptr_q        <= '0;
            count_q        <= '0;
            ack_valid_q    <= 1'b0;
            ack_tag_q      <= '0;
            misalign_err_q <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            w_ptr_q        <= w_ptr_d;
            r_ptr_q        <= r_ptr_d;
            count_q        <= count_d;
            ack_valid_q    <= ack_valid_d;
            ack_tag_q      <= ack_tag_d;
            misalign_err_q <= misalign_err_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Entry payload registers
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        tag_q   <= tag_d;
    end

    // Forwarding search from the youngest entry (w_ptr-1) back to the oldest;
    // the first valid word match decides between hit and stall
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        logic [3:0]    overlap;
        found    = 1'b0;
        idx      = '0;
        overlap  = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        ld_stall = 1'b0;
        if (ld_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx     = w_ptr_q - PW'(1) - PW'(i);
                overlap = be_q[idx] & ld_be;
                if (!found && valid_q[idx] && (addr_q[idx] == ld_addr[31:2])) begin
                    if (overlap == ld_be) begin
                        found    = 1'b1;
                        fwd_hit  = 1'b1;
                        fwd_data = wdata_q[idx];
                    end else if (overlap != 4'b0000) begin
                        found    = 1'b1;
                        ld_stall = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed testbench for store_commit_buffer with hand-computed expectations.
module tb_store_commit_buffer;

    localparam int TAG_W = 5;

    logic             clk;
    logic             reset;
    logic             store_wb;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_is_half;
    logic [TAG_W-1:0] st_rob_tag;
    logic             buf_full;
    logic             buf_empty;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ready;
    logic             ack_valid;
    logic [TAG_W-1:0] ack_tag;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic [3:0]       ld_be;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
    logic             ld_stall;
    logic             misalign_err;
    logic             overflow_err;

    int total;
    int bad;

    store_commit_buffer #(
        .DEPTH (4),
        .TAG_W (TAG_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .store_wb     (store_wb),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_is_half   (st_is_half),
        .st_rob_tag   (st_rob_tag),
        .buf_full     (buf_full),
        .buf_empty    (buf_empty),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ready    (mem_ready),
        .ack_valid    (ack_valid),
        .ack_tag      (ack_tag),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_be        (ld_be),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .ld_stall     (ld_stall),
        .misalign_err (misalign_err),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle retired store pulse
    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic half, input logic [TAG_W-1:0] t);
        store_wb   = 1'b1;
        st_addr    = a;
        st_data    = d;
        st_is_half = half;
        st_rob_tag = t;
        tick();
        store_wb   = 1'b0;
    endtask

    // Combinational load lookup
    task automatic lookup(input logic [31:0] a, input logic [3:0] be);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_be    = be;
        #1;
    endtask

    logic [31:0] exp_head [4];
    logic [31:0] exp_addr;

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        store_wb   = 1'b0;
        st_addr    = '0;
        st_data    = '0;
        st_is_half = 1'b0;
        st_rob_tag = '0;
        mem_ready  = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        ld_be      = '0;
        tick();
        tick();
        check("rst_mem_we",    32'(mem_we), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be",    32'(mem_be), 32'd0);
        check("rst_empty",     32'(buf_empty), 32'd1);
        check("rst_full",      32'(buf_full), 32'd0);
        check("rst_ack",       32'(ack_valid), 32'd0);
        check("rst_ack_tag",   32'(ack_tag), 32'd0);
        check("rst_mis",       32'(misalign_err), 32'd0);
        check("rst_ovf",       32'(overflow_err), 32'd0);
        reset = 1'b0;
        tick();

        // Single sw, memory always ready
        mem_ready = 1'b1;
        store(32'h100, 32'hDEADBEEF, 1'b0, 5'd3);
        check("sw_we",    32'(mem_we), 32'd1);
        check("sw_addr",  mem_addr, 32'h100);
        check("sw_be",    32'(mem_be), 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_ack_early", 32'(ack_valid), 32'd0);
        tick();
        check("sw_ack",     32'(ack_valid), 32'd1);
        check("sw_ack_tag", 32'(ack_tag), 32'd3);
        check("sw_empty",   32'(buf_empty), 32'd1);
        check("sw_we_off",  32'(mem_we), 32'd0);
        tick();
        check("sw_ack_pulse", 32'(ack_valid), 32'd0);

        // Halfword lanes
        mem_ready = 1'b0;
        store(32'h206, 32'h0000ABCD, 1'b1, 5'd7);
        check("shhi_addr",  mem_addr, 32'h204);
        check("shhi_be",    32'(mem_be), 32'hC);
        check("shhi_wdata", mem_wdata, 32'hABCDABCD);
        tick();
        check("hold_addr",  mem_addr, 32'h204);
        check("hold_we",    32'(mem_we), 32'd1);
        mem_ready = 1'b1;
        tick();
        check("shhi_ack",   32'(ack_tag), 32'd7);
        mem_ready = 1'b0;
        store(32'h204, 32'h00001234, 1'b1, 5'd8);
        check("shlo_addr",  mem_addr, 32'h204);
        check("shlo_be",    32'(mem_be), 32'h3);
        check("shlo_wdata", mem_wdata, 32'h12341234);
        mem_ready = 1'b1;
        tick();
        check("shlo_ack",   32'(ack_tag), 32'd8);
        tick();

        // Misalignment
        store(32'h102, 32'h1, 1'b0, 5'd9);
        check("mis_sw_err",   32'(misalign_err), 32'd1);
        check("mis_sw_we",    32'(mem_we), 32'd0);
        check("mis_sw_empty", 32'(buf_empty), 32'd1);
        tick();
        check("mis_pulse",    32'(misalign_err), 32'd0);
        store(32'h101, 32'h2, 1'b1, 5'd10);
        check("mis_sh_err",   32'(misalign_err), 32'd1);
        check("mis_sh_we",    32'(mem_we), 32'd0);
        tick();
        check("mis_no_ack",   32'(ack_valid), 32'd0);

        // Fill, overflow, then drain with a concurrent store and pointer wrap
        mem_ready = 1'b0;
        store(32'h500, 32'hA0000001, 1'b0, 5'd1);
        store(32'h504, 32'hA0000002, 1'b0, 5'd2);
        store(32'h508, 32'hA0000003, 1'b0, 5'd3);
        check("fill_notfull", 32'(buf_full), 32'd0);
        store(32'h50C, 32'hA0000004, 1'b0, 5'd4);
        check("fill_full", 32'(buf_full), 32'd1);
        check("fill_head", mem_addr, 32'h500);
        store(32'h510, 32'hA0000006, 1'b0, 5'd6);
        check("ovf_err",   32'(overflow_err), 32'd1);
        check("ovf_full",  32'(buf_full), 32'd1);
        check("ovf_head",  mem_addr, 32'h500);
        mem_ready = 1'b1;
        store(32'h514, 32'hA0000005, 1'b0, 5'd5);
        check("pop_ack",      32'(ack_valid), 32'd1);
        check("pop_ack_tag",  32'(ack_tag), 32'd1);
        check("pop_no_ovf",   32'(overflow_err), 32'd0);
        check("pop_full",     32'(buf_full), 32'd1);
        exp_head[0] = 32'h504;
        exp_head[1] = 32'h508;
        exp_head[2] = 32'h50C;
        exp_head[3] = 32'h514;
        for (int k = 0; k < 4; k++) begin
            exp_addr = exp_head[k];
            check("drain_head", mem_addr, exp_addr);
            tick();
            check("drain_ack",     32'(ack_valid), 32'd1);
            check("drain_ack_tag", 32'(ack_tag), 32'(k + 2));
        end
        check("drain_empty", 32'(buf_empty), 32'd1);
        check("drain_we",    32'(mem_we), 32'd0);
        tick();

        // Forwarding: youngest matching word wins
        mem_ready = 1'b0;
        store(32'h300, 32'h11111111, 1'b0, 5'd11);
        store(32'h300, 32'h22222222, 1'b0, 5'd12);
        lookup(32'h300, 4'b1111);
        check("fwd_hit",   32'(fwd_hit), 32'd1);
        check("fwd_data",  fwd_data, 32'h22222222);
        check("fwd_stall", 32'(ld_stall), 32'd0);
        lookup(32'h304, 4'b1111);
        check("miss_hit",  32'(fwd_hit), 32'd0);
        check("miss_data", fwd_data, 32'd0);
        check("miss_stall", 32'(ld_stall), 32'd0);
        ld_valid = 1'b0;
        ld_addr  = 32'h300;
        #1;
        check("noreq_hit", 32'(fwd_hit), 32'd0);
        // Store in the same cycle as the lookup is not visible yet
        store_wb   = 1'b1;
        st_addr    = 32'h304;
        st_data    = 32'h33333333;
        st_is_half = 1'b0;
        st_rob_tag = 5'd14;
        lookup(32'h304, 4'b1111);
        check("samecyc_hit", 32'(fwd_hit), 32'd0);
        tick();
        store_wb = 1'b0;
        #1;
        check("nextcyc_hit",  32'(fwd_hit), 32'd1);
        check("nextcyc_data", fwd_data, 32'h33333333);
        // Head being popped still forwards
        lookup(32'h300, 4'b1111);
        mem_ready = 1'b1;
        #1;
        check("pophead_data", fwd_data, 32'h22222222);
        ld_valid = 1'b0;
        tick();
        tick();
        tick();
        check("fwd_drained", 32'(buf_empty), 32'd1);
        tick();

        // Partial coverage stalls; reset mid-drain discards entries
        mem_ready = 1'b0;
        store(32'h402, 32'h0000BEEF, 1'b1, 5'd13);
        lookup(32'h400, 4'b1111);
        check("part_stall", 32'(ld_stall), 32'd1);
        check("part_hit",   32'(fwd_hit), 32'd0);
        lookup(32'h400, 4'b1100);
        check("upper_hit",  32'(fwd_hit), 32'd1);
        check("upper_data", fwd_data, 32'hBEEFBEEF);
        lookup(32'h400, 4'b0011);
        check("disj_hit",   32'(fwd_hit), 32'd0);
        check("disj_stall", 32'(ld_stall), 32'd0);
        ld_valid = 1'b0;
        check("pre_rst_we", 32'(mem_we), 32'd1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("mid_rst_we",    32'(mem_we), 32'd0);
        check("mid_rst_empty", 32'(buf_empty), 32'd1);
        check("mid_rst_ack",   32'(ack_valid), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ack", 32'(ack_valid), 32'd0);
        check("post_rst_we",  32'(mem_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
